// File: rtl/mips_pkg.sv
// Shared MIPS encodings for the project2 multi-cycle datapath and its control unit.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXE    = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWR  = 4'd5,
        S_ALUWB  = 4'd6,
        S_MEMWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    // Also consumed by the immediate extender, so these codes must stay in sync with it.
    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;

    localparam logic [1:0] NPC_PC4    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_RS     = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_DM  = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] RD_RD = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    typedef struct packed {
        logic ralu;
        logic ialu;
        logic load;
        logic store;
        logic branch;
        logic jump;
        logic jal;
        logic jr;
    } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: opcode/funct to instruction class plus the
// state-independent datapath controls.
module mc_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    iclass,
    output logic [1:0] extop,
    output logic [2:0] aluop,
    output logic       bsel,
    output logic       illegal
);

    always_comb begin
        iclass  = '0;
        extop   = EXT_ZERO;
        aluop   = ALU_ADD;
        bsel    = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: iclass.ralu = 1'b1;
                    FN_SUBU: begin
                        iclass.ralu = 1'b1;
                        aluop       = ALU_SUB;
                    end
                    FN_SLT: begin
                        iclass.ralu = 1'b1;
                        aluop       = ALU_SLT;
                    end
                    FN_JR:   iclass.jr = 1'b1;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ORI: begin
                iclass.ialu = 1'b1;
                bsel        = 1'b1;
                aluop       = ALU_OR;
            end
            OP_ADDIU: begin
                iclass.ialu = 1'b1;
                bsel        = 1'b1;
                extop       = EXT_SIGN;
            end
            // lui adds the shifted immediate to $0, which the datapath selects as rs.
            OP_LUI: begin
                iclass.ialu = 1'b1;
                bsel        = 1'b1;
                extop       = EXT_LUI;
            end
            OP_LW: begin
                iclass.load = 1'b1;
                bsel        = 1'b1;
                extop       = EXT_SIGN;
            end
            OP_SW: begin
                iclass.store = 1'b1;
                bsel         = 1'b1;
                extop        = EXT_SIGN;
            end
            OP_BEQ: begin
                iclass.branch = 1'b1;
                extop         = EXT_SIGN;
                aluop         = ALU_SUB;
            end
            OP_J:    iclass.jump = 1'b1;
            OP_JAL:  iclass.jal  = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: state sequencer, Moore output decode and
// retired-instruction counter.
module mc_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pcwr,
    output logic             irwr,
    output logic             gprwr,
    output logic             dmwr,
    output logic [1:0]       extop,
    output logic [2:0]       aluop,
    output logic             bsel,
    output logic [1:0]       regdst,
    output logic [1:0]       wbsel,
    output logic [1:0]       npc_op,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     cur, nxt;
    iclass_t    iclass;
    logic [1:0] dec_extop;
    logic [2:0] dec_aluop;
    logic       dec_bsel;
    logic       dec_illegal;
    logic       retire;

    mc_decode u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .iclass  (iclass),
        .extop   (dec_extop),
        .aluop   (dec_aluop),
        .bsel    (dec_bsel),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= S_FETCH;
        else        cur <= nxt;
    end

    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: begin
                if (iclass.ralu || iclass.ialu)                 nxt = S_EXE;
                else if (iclass.load || iclass.store)           nxt = S_MEMADR;
                else if (iclass.branch)                         nxt = S_BRANCH;
                else if (iclass.jump || iclass.jal || iclass.jr) nxt = S_JUMP;
                else                                            nxt = S_FETCH;
            end
            S_EXE:    nxt = S_ALUWB;
            S_MEMADR: nxt = iclass.load ? S_MEMRD : S_MEMWR;
            S_MEMRD:  nxt = S_MEMWB;
            default:  nxt = S_FETCH;
        endcase
    end

    // Illegal instructions leave DECODE straight for FETCH and so never retire.
    assign retire = (cur == S_ALUWB) || (cur == S_MEMWB) || (cur == S_MEMWR) ||
                    (cur == S_BRANCH) || (cur == S_JUMP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      instret <= '0;
        else if (retire) instret <= instret + CNT_ONE;
    end

    always_comb begin
        pcwr    = 1'b0;
        irwr    = 1'b0;
        gprwr   = 1'b0;
        dmwr    = 1'b0;
        illegal = 1'b0;
        regdst  = RD_RD;
        wbsel   = WB_ALU;
        npc_op  = NPC_PC4;
        extop   = (cur == S_FETCH) ? EXT_ZERO : dec_extop;
        aluop   = dec_aluop;
        bsel    = dec_bsel;
        case (cur)
            S_FETCH: begin
                pcwr = 1'b1;
                irwr = 1'b1;
            end
            S_DECODE: illegal = dec_illegal;
            S_ALUWB: begin
                gprwr  = 1'b1;
                regdst = iclass.ralu ? RD_RD : RD_RT;
            end
            S_MEMWB: begin
                gprwr  = 1'b1;
                wbsel  = WB_DM;
                regdst = RD_RT;
            end
            S_MEMWR:  dmwr = 1'b1;
            S_BRANCH: begin
                pcwr   = zero;
                npc_op = NPC_BRANCH;
            end
            S_JUMP: begin
                pcwr   = 1'b1;
                npc_op = iclass.jr ? NPC_RS : NPC_JUMP;
                if (iclass.jal) begin
                    gprwr  = 1'b1;
                    regdst = RD_RA;
                    wbsel  = WB_PC4;
                end
            end
            default: ;
        endcase
        // The state register is held at FETCH during reset, so its enables must be masked here.
        if (!rst_n) begin
            pcwr    = 1'b0;
            irwr    = 1'b0;
            gprwr   = 1'b0;
            dmwr    = 1'b0;
            illegal = 1'b0;
        end
    end

    assign state = cur;

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle MIPS control unit for the project2 datapath. Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives all datapath write enables and mux selects, including the 2-bit extop consumed by the immediate extender directly downstream. Sits between the instruction register (opcode/funct source) and the datapath (PC, IR, GPR, ALU, DM, ext).

Parameters:
CNT_W, 32, width of retired-instruction counter instret.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
opcode  input  6  IR[31:26], stable from DECODE until the next FETCH.
funct  input  6  IR[5:0], meaningful when opcode=000000.
zero  input  1  ALU zero flag, sampled in BRANCH.
pcwr  output  1  PC write enable.
irwr  output  1  IR write enable.
gprwr  output  1  register-file write enable.
dmwr  output  1  data-memory write enable.
extop  output  2  00 zero-extend, 01 sign-extend, 10 lui (imm16<<16).
aluop  output  3  000 add, 001 sub, 010 or, 011 slt.
bsel  output  1  ALU B source: 0 GPR rt, 1 ext output.
regdst  output  2  00 rd, 01 rt, 10 $31.
wbsel  output  2  00 ALU result, 01 DM data, 10 PC+4.
npc_op  output  2  00 PC+4, 01 branch target, 10 jump target, 11 GPR rs.
illegal  output  1  one-cycle pulse in DECODE for an unsupported opcode/funct.
instret  output  CNT_W  count of completed instructions.
state  output  4  current state (debug).

Behaviour:
- Supported: addu, subu, slt, jr (R-type); ori, addiu, lui, lw, sw, beq, j, jal.
- States: FETCH=0, DECODE=1, EXE=2, MEMADR=3, MEMRD=4, MEMWR=5, ALUWB=6, MEMWB=7, BRANCH=8, JUMP=9. Codes 10-15 return to FETCH on the next edge with no enables asserted.
- Transitions: FETCH->DECODE always. From DECODE:
  - R-type ALU ops, ori, addiu and lui go to EXE.
  - lw and sw go to MEMADR.
  - beq goes to BRANCH.
  - j, jal and jr go to JUMP.
  - Illegal instructions go to FETCH.
- Continuations: EXE->ALUWB->FETCH. MEMADR->MEMRD (lw) or MEMWR (sw). MEMRD->MEMWB->FETCH. MEMWR, BRANCH and JUMP go to FETCH.
- Latency in cycles: ALU ops 4, lw 5, sw 4, beq 3, j/jal/jr 3, illegal 2.
- Outputs are Moore-style: decoded from the state register plus opcode/funct. No output is registered separately except instret.
- FETCH: irwr=1, pcwr=1, npc_op=00. Every other enable is 0.
- extop decodes from opcode in every state except FETCH, where it is 00:
  - ori gives 00.
  - addiu, lw, sw and beq give 01.
  - lui gives 10.
  - All others give 00.
- bsel=1 for ori, addiu, lui, lw and sw.
- aluop:
  - lui uses add, with ext output plus 0 selected via the datapath rs=$0.
  - beq uses sub.
  - ori uses or.
  - slt uses slt.
  - Everything else uses add.
- ALUWB: gprwr=1, wbsel=00. regdst=00 for R-type, 01 for I-type.
- MEMWB: gprwr=1, wbsel=01, regdst=01. MEMWR: dmwr=1.
- BRANCH: pcwr=zero, npc_op=01.
- JUMP:
  - pcwr=1. npc_op=10 for j and jal, 11 for jr.
  - jal additionally asserts gprwr=1, regdst=10, wbsel=10 in the same cycle.
- instret increments on every transition into FETCH from ALUWB, MEMWB, MEMWR, BRANCH or JUMP. Illegal instructions do not count. instret wraps modulo 2^CNT_W.
- Reset:
  - Asynchronous assertion forces state=FETCH and instret=0.
  - While rst_n=0, pcwr, irwr, gprwr, dmwr and illegal are forced to 0.
  - Reset mid-instruction abandons it with no further writes.
  - The first post-reset rising edge performs a normal FETCH.
- The zero input is ignored outside BRANCH. opcode/funct changes during FETCH have no effect on state.

Decomposition:
- Shared package mips_pkg holds:
  - opcode and funct constants.
  - state encodings.
  - EXT_ZERO/EXT_SIGN/EXT_LUI.
  - ALU_ADD/SUB/OR/SLT.
  - NPC_* and WB_*/RD_* codes.
  - The same EXT_* codes are used by the extender.
- One sub-module, mc_decode: purely combinational. Maps opcode/funct to an instruction-class one-hot plus extop, aluop, bsel and illegal. mc_ctrl holds the FSM, the output gating and instret.

Test Plan:
- Reset held 3 cycles then released, opcode=001101 (ori) -> state sequence 0,1,2,6,0. extop=00 from DECODE through ALUWB. gprwr=1 only in ALUWB with regdst=01. instret=1.
- lw (100011) -> states 0,1,3,4,7,0 (5 cycles). extop=01, bsel=1, gprwr=1 with wbsel=01 in MEMWB only.
- beq (000100) with zero=1, then with zero=0 -> 3 cycles each. pcwr=1 with npc_op=01 in BRANCH only when zero=1. aluop=001.
- lui (001111) then jal (000011) -> lui gives extop=10. jal gives pcwr=1, npc_op=10, gprwr=1, regdst=10, wbsel=10 in JUMP. instret +2.
- opcode=111111 -> illegal=1 in DECODE, back to FETCH after 2 cycles, no gprwr/dmwr, instret unchanged.
- rst_n dropped asynchronously mid-MEMWR of sw -> dmwr falls immediately, state=0, instret=0. After release, FETCH resumes normally.
